dmem_responder: RTL

//  Word-organised data-memory responder for the MIPS core's load/store path.
//  The core issues one request at a time over a valid/ready request channel.
//  The block inserts a fixed number of wait states, then performs the access.
//  It returns data or an error over a valid/ready response channel.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: valid/ready request in, fixed wait
// states, then a single access and a held valid/ready response.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic                  r_resp_err;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_access;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_idx;
  logic [31:0]           w_acc_wdata;
  logic [3:0]            w_acc_be;
  logic                  w_acc_err;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // With no wait states the access happens on the accept edge itself, so the
  // access path takes the live request instead of the latched copy.
  assign w_access    = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_acc_we    = (r_state == IDLE) ? req_we                        : r_we;
  assign w_acc_idx   = (r_state == IDLE) ? req_addr[ADDR_WIDTH+1:2]      : r_idx;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata                     : r_wdata;
  assign w_acc_be    = (r_state == IDLE) ? req_be                        : r_be;
  assign w_acc_err   = (r_state == IDLE) ? w_req_err                     : r_err;

  always_ff @(posedge clk) begin
    if (w_access && !reset && w_acc_we && !w_acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_access) begin
        r_rdata    <= (!w_acc_we && !w_acc_err) ? r_mem[w_acc_idx] : '0;
        r_resp_err <= w_acc_err;
      end
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_idx   <= req_addr[ADDR_WIDTH+1:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_err   <= w_req_err;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_resp_err;

endmodule
